// File: rtl/load_extend_ctrl_if.sv
// Bundles the MEM-stage load request/response and data-memory read port of load_extend_ctrl.
// The slave modport is the controller's view; master is the pipeline and memory side.
interface load_extend_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic              mem_read;
  logic [31:0]       mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic              stall;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_addr, req_size, req_signed, mem_ack, mem_data,
    output req_ready, mem_read, mem_addr, stall, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_size, req_signed, mem_ack, mem_data,
    input  req_ready, mem_read, mem_addr, stall, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/load_extend_ctrl.sv
// Sub-word load sequencer: word-aligned read, lane select, sign/zero extension, stall.
// Optional LOAD_ALIGN_CHECK_EN macro rejects misaligned half/word loads without a memory read.
module load_extend_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  load_extend_ctrl_if.slave bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state, state_nx;
  logic [31:0]       addr_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              misalign_q;
  logic              misalign_req;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_nx;
  logic              rsp_err_q, rsp_err_nx;
  logic [DATA_W-1:0] ext_data;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;

`ifdef LOAD_ALIGN_CHECK_EN
  assign misalign_req = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                        (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`else
  assign misalign_req = 1'b0;
`endif

  // Little-endian lanes; size 2'b11 is handled as a word.
  assign byte_lane = bus.mem_data[8*addr_q[1:0] +: 8];
  assign half_lane = bus.mem_data[16*addr_q[1] +: 16];

  always_comb begin
    case (size_q)
      2'b00:   ext_data = {{(DATA_W-8){sign_q & byte_lane[7]}}, byte_lane};
      2'b01:   ext_data = {{(DATA_W-16){sign_q & half_lane[15]}}, half_lane};
      default: ext_data = bus.mem_data;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_nx    = state;
    cnt_nx      = cnt_q;
    rsp_data_nx = rsp_data_q;
    rsp_err_nx  = rsp_err_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        cnt_nx = '0;
        if (misalign_q) begin
          state_nx    = DONE;
          rsp_data_nx = '0;
          rsp_err_nx  = 1'b1;
        end else if (bus.mem_ack) begin
          state_nx    = DONE;
          rsp_data_nx = ext_data;
          rsp_err_nx  = 1'b0;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // An acknowledge on the final wait cycle still wins over the timeout.
        if (bus.mem_ack) begin
          state_nx    = DONE;
          rsp_data_nx = ext_data;
          rsp_err_nx  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_nx    = DONE;
          rsp_data_nx = '0;
          rsp_err_nx  = 1'b1;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      misalign_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt_q      <= cnt_nx;
      rsp_data_q <= rsp_data_nx;
      rsp_err_q  <= rsp_err_nx;
      if (state == IDLE && bus.req_valid) begin
        addr_q     <= bus.req_addr;
        size_q     <= bus.req_size;
        sign_q     <= bus.req_signed;
        misalign_q <= misalign_req;
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.stall     = (state != IDLE);
  assign bus.mem_read  = (state == ISSUE && !misalign_q) || (state == WAIT);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
